// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I pipeline encodings (ALU ops, forward selects,
//               writeback selects, branch funct3 codes).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/execute_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational RV32I integer ALU with zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  logic [4:0] w_shamt;
  assign w_shamt = SrcB[4:0];

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_XOR: Result = SrcA ^ SrcB;
      ALU_SLT: Result = {{(DATA_W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLL: Result = SrcA << w_shamt;
      ALU_SRL: Result = SrcA >> w_shamt;
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : RV32I EX stage - operand bypass, ALU, branch/jump resolution
//               and the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              ALUSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              JalrE,
  input  logic [2:0]        Funct3E,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [DATA_W-1:0] ALU_ResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M
);

  logic [DATA_W-1:0] w_src_a;
  logic [DATA_W-1:0] w_write_data;
  logic [DATA_W-1:0] w_src_b;
  logic [DATA_W-1:0] w_alu_result;
  logic [DATA_W-1:0] w_target_sum;
  logic              w_zero;
  logic              w_lt_s;
  logic              w_lt_u;
  logic              w_cond;

  // Code 11 is unused by the hazard unit and falls back to register data.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] wb,
    input logic [DATA_W-1:0] mem
  );
    case (sel)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

  assign w_src_a      = fwd_sel(ForwardAE, RD1_E, ResultW, ALU_ResultM);
  assign w_write_data = fwd_sel(ForwardBE, RD2_E, ResultW, ALU_ResultM);
  assign w_src_b      = ALUSrcE ? Imm_Ext_E : w_write_data;

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .SrcA       (w_src_a),
    .SrcB       (w_src_b),
    .ALUControl (ALUControlE),
    .Result     (w_alu_result),
    .Zero       (w_zero)
  );

  // Relational branches compare operands directly; only BEQ/BNE use the SUB flag.
  assign w_lt_s = $signed(w_src_a) < $signed(w_src_b);
  assign w_lt_u = w_src_a < w_src_b;

  always_comb begin
    w_cond = 1'b0;
    case (Funct3E)
      F3_BEQ:  w_cond = w_zero;
      F3_BNE:  w_cond = ~w_zero;
      F3_BLT:  w_cond = w_lt_s;
      F3_BGE:  w_cond = ~w_lt_s;
      F3_BLTU: w_cond = w_lt_u;
      F3_BGEU: w_cond = ~w_lt_u;
      default: w_cond = 1'b0;
    endcase
  end

  assign PCSrcE       = rst & (JumpE | (BranchE & w_cond));
  assign w_target_sum = (JalrE ? w_src_a : PCE) + Imm_Ext_E;
  assign PCTargetE    = JalrE ? {w_target_sum[DATA_W-1:1], 1'b0} : w_target_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= '0;
      RD_M        <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      ALU_ResultM <= w_alu_result;
      WriteDataM  <= w_write_data;
      PCPlus4M    <= PCPlus4E;
    end
  end

endmodule
`default_nettype wire
